// File: rtl/mmio_io_bank.sv
// mmio_io_bank
// Memory-mapped I/O bank that sits beside data RAM on the processor's data
// port. It gives the processor synchronised input words, writable output
// registers, sticky rising-edge flags (e.g. button presses) and a
// free-running frame-tick counter for game timing. Read data comes back one
// cycle after the address, like RAM, so the wrapper can pick between
// dataOut and RAM data using hit.
//
// Register window (word offset inside the 64-word window at BASE_ADDR):
//   0x00+i  input word i (synchronised), read-only
//   0x10+j  output register j, read/write
//   0x20    edge flags, read-only, cleared by a plain read
//   0x21    frame tick counter, read/write (a write also restarts the prescaler)
//   0x22    status {31'b0, tick_pending}, read-only, cleared by a plain read
//   anything else reads 0 and ignores writes
//
// Ports:
//   clock    in   1           system clock, all logic on posedge
//   reset    in   1           asynchronous, active-high
//   wEn      in   1           data-memory write enable
//   addr     in   12          data-memory word address
//   dataIn   in   32          data-memory write data
//   dataOut  out  32          registered read data
//   hit      out  1           registered: previous address was in this window
//   in_bus   in   NUM_IN*32   external inputs, channel i at [32i+31:32i]
//   out_bus  out  NUM_OUT*32  output registers, channel j at [32j+31:32j]
//   tick     out  1           one-cycle pulse at each frame tick

module mmio_io_bank #(
    parameter int          NUM_IN      = 2,
    parameter int          NUM_OUT     = 2,
    parameter logic [11:0] BASE_ADDR   = 12'hF00,
    parameter int          TICK_DIV    = 500000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wEn,
    input  logic [11:0]             addr,
    input  logic [31:0]             dataIn,
    output logic [31:0]             dataOut,
    output logic                    hit,
    input  logic [NUM_IN*32-1:0]    in_bus,
    output logic [NUM_OUT*32-1:0]   out_bus,
    output logic                    tick
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [5:0] OFF_EDGE = 6'h20;
    localparam logic [5:0] OFF_TCNT = 6'h21;
    localparam logic [5:0] OFF_STAT = 6'h22;

    // State registers
    logic [NUM_IN*32-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_IN*32-1:0]  sync_d [SYNC_STAGES];
    logic [NUM_IN-1:0]     in_prev_q, in_prev_d;
    logic [NUM_IN-1:0]     edge_q, edge_d;
    logic [NUM_OUT*32-1:0] out_q, out_d;
    logic [31:0]           tcnt_q, tcnt_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  pend_q, pend_d;
    logic                  tick_q, tick_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  hit_q, hit_d;

    // Decode and helper signals
    logic                  sel;
    logic [5:0]            off;
    logic                  do_write;
    logic                  do_read;
    logic                  tcnt_wr;
    logic                  wrap;
    logic                  tick_set;
    logic [NUM_IN*32-1:0]  in_sync;
    logic [NUM_IN-1:0]     rise;
    logic [31:0]           rd_data;

    assign in_sync = sync_q[SYNC_STAGES-1];

    // Address decode. A "read" that clears sticky bits is only a cycle with
    // wEn low; a write cycle still returns data but never clears anything.
    always_comb begin
        sel      = (addr[11:6] == BASE_ADDR[11:6]);
        off      = addr[5:0];
        do_write = sel & wEn;
        do_read  = sel & ~wEn;
        tcnt_wr  = do_write && (off == OFF_TCNT);
        wrap     = (presc_q == PRESC_LAST);
        // A counter load in the same cycle as a wrap takes priority, so the
        // wrap side effects are dropped entirely.
        tick_set = wrap & ~tcnt_wr;
    end

    // Input synchroniser chains and rising-edge detection on bit 0 of each
    // synchronised word.
    always_comb begin
        sync_d[0] = in_bus;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        in_prev_d = '0;
        rise      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_prev_d[i] = in_sync[i*32];
            rise[i]      = in_sync[i*32] & ~in_prev_q[i];
        end
    end

    // Sticky flags: a clearing read and a new event in the same cycle leave
    // the flag set, so no press or tick is ever lost.
    always_comb begin
        edge_d = ((do_read && (off == OFF_EDGE)) ? '0 : edge_q) | rise;
        pend_d = ((do_read && (off == OFF_STAT)) ? 1'b0 : pend_q) | tick_set;
    end

    // Prescaler and frame tick counter.
    always_comb begin
        presc_d = presc_q + PW'(1);
        tcnt_d  = tcnt_q;
        tick_d  = 1'b0;
        if (tcnt_wr) begin
            presc_d = '0;
            tcnt_d  = dataIn;
        end else if (wrap) begin
            presc_d = '0;
            tcnt_d  = tcnt_q + 32'd1;
            tick_d  = 1'b1;
        end
    end

    // Output registers; offsets beyond NUM_OUT simply never match.
    always_comb begin
        out_d = out_q;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (do_write && (off == 6'(16 + j))) begin
                out_d[j*32 +: 32] = dataIn;
            end
        end
    end

    // Read mux, built from current (pre-write) register values.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (off == 6'(i)) begin
                rd_data = in_sync[i*32 +: 32];
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (off == 6'(16 + j)) begin
                rd_data = out_q[j*32 +: 32];
            end
        end
        case (off)
            OFF_EDGE: rd_data = 32'(edge_q);
            OFF_TCNT: rd_data = tcnt_q;
            OFF_STAT: rd_data = {31'b0, pend_q};
            default:  ;
        endcase
        data_out_d = sel ? rd_data : 32'd0;
        hit_d      = sel;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            in_prev_q  <= '0;
            edge_q     <= '0;
            out_q      <= '0;
            tcnt_q     <= '0;
            presc_q    <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            data_out_q <= '0;
            hit_q      <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            in_prev_q  <= in_prev_d;
            edge_q     <= edge_d;
            out_q      <= out_d;
            tcnt_q     <= tcnt_d;
            presc_q    <= presc_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
        end
    end

    assign dataOut = data_out_q;
    assign hit     = hit_q;
    assign out_bus = out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_mmio_io_bank.sv
// tb_mmio_io_bank
// Scoreboard bench for mmio_io_bank with a small frame-tick divider so that
// tick behaviour is visible in a few cycles. Stimulus drives on the falling
// edge and queues what the DUT must show after the next rising edge; an
// independent monitor pops and compares.

module tb_mmio_io_bank;

    localparam int NUM_IN  = 2;
    localparam int NUM_OUT = 2;

    localparam int KRD   = 0;
    localparam int KOUT  = 1;
    localparam int KTICK = 2;

    typedef struct {
        int          kind;
        int          stamp;
        logic [63:0] exp;
        string       name;
    } sb_entry_t;

    logic                  clock;
    logic                  reset;
    logic                  wEn;
    logic [11:0]           addr;
    logic [31:0]           dataIn;
    logic [31:0]           dataOut;
    logic                  hit;
    logic [NUM_IN*32-1:0]  in_bus;
    logic [NUM_OUT*32-1:0] out_bus;
    logic                  tick;

    sb_entry_t sb[$];
    int        cyc         = 0;
    int        nCompared   = 0;
    int        nMismatched = 0;

    mmio_io_bank #(
        .NUM_IN      (NUM_IN),
        .NUM_OUT     (NUM_OUT),
        .BASE_ADDR   (12'hF00),
        .TICK_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .wEn     (wEn),
        .addr    (addr),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .hit     (hit),
        .in_bus  (in_bus),
        .out_bus (out_bus),
        .tick    (tick)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one scoreboard entry against what the DUT shows now.
    task automatic checkOutput(input sb_entry_t e);
        logic [63:0] act;
        case (e.kind)
            KRD:     act = {31'b0, hit, dataOut};
            KOUT:    act = 64'(out_bus);
            default: act = {63'b0, tick};
        endcase
        nCompared++;
        if (act !== e.exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.exp, cyc);
        end
    endtask

    // Monitor: after every rising edge, retire the entries issued on the
    // previous cycle.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].stamp < cyc) begin
                e = sb.pop_front();
                if (e.stamp != cyc - 1) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL %s: stale entry, issued %0d, now %0d", e.name, e.stamp, cyc);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    // Drive one bus cycle and queue the expected {hit, dataOut}.
    task automatic applyStimulus(input logic [11:0] a, input logic we, input logic [31:0] d,
                                 input logic [31:0] expData, input logic expHit, input string name);
        sb_entry_t e;
        addr   = a;
        wEn    = we;
        dataIn = d;
        e.kind  = KRD;
        e.stamp = cyc;
        e.exp   = {31'b0, expHit, expData};
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic expectOut(input logic [63:0] expBus, input string name);
        sb_entry_t e;
        e.kind  = KOUT;
        e.stamp = cyc;
        e.exp   = expBus;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic expectTick(input logic expTick, input string name);
        sb_entry_t e;
        e.kind  = KTICK;
        e.stamp = cyc;
        e.exp   = {63'b0, expTick};
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic stepCycle();
        @(negedge clock);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] expData, input string name);
        applyStimulus(a, 1'b0, 32'd0, expData, 1'b1, name);
        stepCycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(12'h000, 1'b0, 32'd0, 32'd0, 1'b0, "idle_miss");
            stepCycle();
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        addr  = 12'h000;
        wEn   = 1'b0;
        stepCycle();
        reset = 1'b0;
    endtask

    // Stimulus
    initial begin
        reset  = 1'b1;
        wEn    = 1'b0;
        addr   = 12'h000;
        dataIn = 32'd0;
        in_bus = '0;
        @(negedge clock);
        reset = 1'b0;

        // Reset values, status read first before the first wrap sets it
        rd(12'hF22, 32'd0, "rst_status");
        rd(12'hF21, 32'd0, "rst_tcnt");
        rd(12'hF20, 32'd0, "rst_edges");
        rd(12'hF10, 32'd0, "rst_out0");
        rd(12'hF11, 32'd0, "rst_out1");

        // Output registers: write returns the old value, readback, unmapped
        applyStimulus(12'hF11, 1'b1, 32'hDEADBEEF, 32'd0, 1'b1, "wr_out1_prev");
        expectOut({32'hDEADBEEF, 32'h0}, "out_bus_after_wr1");
        stepCycle();
        rd(12'hF11, 32'hDEADBEEF, "readback_out1");
        applyStimulus(12'hF10, 1'b1, 32'h11111111, 32'd0, 1'b1, "wr_out0_prev");
        expectOut({32'hDEADBEEF, 32'h11111111}, "out_bus_after_wr0");
        stepCycle();
        applyStimulus(12'hF15, 1'b1, 32'h12345678, 32'd0, 1'b1, "wr_unmapped15");
        expectOut({32'hDEADBEEF, 32'h11111111}, "out_bus_unmapped15");
        stepCycle();
        rd(12'hF15, 32'd0, "read_unmapped15");
        applyStimulus(12'hF12, 1'b1, 32'h0000ABCD, 32'd0, 1'b1, "wr_out2_beyond");
        stepCycle();
        rd(12'hF12, 32'd0, "read_out2_beyond");
        rd(12'hF02, 32'd0, "read_in2_beyond");
        rd(12'hF3F, 32'd0, "read_top_offset");

        // Outside the window: no hit, no write side effect
        applyStimulus(12'h010, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, "miss_wr_010");
        expectOut({32'hDEADBEEF, 32'h11111111}, "out_bus_miss_010");
        stepCycle();
        applyStimulus(12'hF50, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, "miss_wr_F50");
        expectOut({32'hDEADBEEF, 32'h11111111}, "out_bus_miss_F50");
        stepCycle();

        // Channel 0 rise lands in the same cycle as the clearing read
        in_bus[31:0] = 32'h00000001;
        idle(2);
        rd(12'hF20, 32'd0, "edge_coincident_old");
        rd(12'hF20, 32'd1, "edge_set_wins");
        rd(12'hF20, 32'd0, "edge_cleared");
        rd(12'hF00, 32'd1, "in_sync0");

        // Falling input does not raise a flag
        in_bus[31:0] = 32'h00000000;
        idle(3);
        rd(12'hF20, 32'd0, "no_edge_on_fall");

        // Channel 1 rise; a write-cycle read does not clear
        in_bus[63:32] = 32'hCAFE0001;
        idle(3);
        rd(12'hF01, 32'hCAFE0001, "in_sync1");
        applyStimulus(12'hF20, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b1, "edge_wr_no_clear");
        stepCycle();
        rd(12'hF20, 32'd2, "edge1_still_set");
        rd(12'hF20, 32'd0, "edge1_cleared");

        // Frame tick with divider 4
        doReset();
        for (int p = 1; p <= 8; p++) begin
            applyStimulus(12'h000, 1'b0, 32'd0, 32'd0, 1'b0, "tick_idle");
            expectTick((p == 4) || (p == 8), "tick_pulse");
            stepCycle();
        end
        rd(12'hF21, 32'd2, "tcnt_after_8");
        applyStimulus(12'hF21, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b1, "tcnt_wr_prev");
        stepCycle();
        for (int p = 1; p <= 4; p++) begin
            applyStimulus(12'h000, 1'b0, 32'd0, 32'd0, 1'b0, "tick_idle2");
            expectTick(p == 4, "tick_after_load");
            stepCycle();
        end
        rd(12'hF21, 32'd0, "tcnt_wrap_to_0");
        rd(12'hF22, 32'd1, "pending_set");
        rd(12'hF22, 32'd0, "pending_cleared");
        applyStimulus(12'hF21, 1'b1, 32'h00000100, 32'd0, 1'b1, "tcnt_wr_on_wrap");
        expectTick(1'b0, "tick_suppressed");
        stepCycle();
        rd(12'hF21, 32'h00000100, "tcnt_write_wins");
        rd(12'hF22, 32'd0, "pending_unchanged");

        // Reset in the middle of a write
        applyStimulus(12'hF10, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, "reset_mid_write");
        expectOut(64'd0, "out_bus_reset");
        expectTick(1'b0, "tick_reset");
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        idle(3);
        rd(12'hF20, 32'd2, "edge_after_reset");
        rd(12'hF10, 32'd0, "out0_after_reset");

        stepCycle();
        stepCycle();
        if (sb.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        nMismatched++;
        $display("[TB] FAIL watchdog: run still active at time %0t, expected finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
